// File: rtl/jpd_pkg.sv
// jpd_pkg: shared types and defaults for the Johnson phase decoder.
package jpd_pkg;

  // Lock tracking states: no reference phase, building a run of steps, locked.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } jpd_state_t;

  // Consecutive legal steps required before lock is declared.
  localparam int LOCK_CNT_DEFAULT = 3;

endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check: combinational decode of an N-bit Johnson code into its
// phase index (0..2N-1), flagging any value that is not a Johnson state.
module johnson_code_check #(
  parameter int N = 4
) (
  input  logic [N-1:0]           jc_in,
  output logic                   legal,
  output logic [$clog2(2*N)-1:0] idx
);

  localparam int IW = $clog2(2*N);

  // Code of phase i: the low i bits set while filling, then zeros
  // shifting in from the bottom while draining.
  function automatic logic [N-1:0] code_of(input int i);
    logic [N:0] ones;
    if (i <= N) begin
      ones = ({{N{1'b0}}, 1'b1} << i) - {{N{1'b0}}, 1'b1};
      return ones[N-1:0];
    end else begin
      ones = ({{N{1'b0}}, 1'b1} << (i - N)) - {{N{1'b0}}, 1'b1};
      return ~ones[N-1:0];
    end
  endfunction

  // Match jc_in against every Johnson state; codes are unique so at most one hits.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (jc_in == code_of(i)) begin
        legal = 1'b1;
        idx   = IW'(i);
      end else begin
        legal = legal;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: decodes a Johnson counter output into a registered
// phase index / one-hot phase and tracks whether the counter is stepping
// cleanly (lock FSM with err pulses on illegal codes or skipped phases).
// Optional feature: define JPD_ERR_COUNT_EN to add an 8-bit saturating err_cnt.
module johnson_phase_decoder
  import jpd_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           jc_in,
  input  logic                   in_valid,
  output logic [$clog2(2*N)-1:0] phase_idx,
  output logic [2*N-1:0]         phase_onehot,
  output logic                   locked,
  output logic                   err
`ifdef JPD_ERR_COUNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  localparam int            IW          = $clog2(2*N);
  localparam logic [IW-1:0] LAST_IDX    = IW'(2*N - 1);
  localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_CNT);

  jpd_state_t      state;
  logic [3:0]      cnt;
  logic            code_legal;
  logic [IW-1:0]   code_idx;
  logic [IW-1:0]   next_idx;
  logic            step_ok;
  logic [3:0]      cnt_inc;
  logic [2*N-1:0]  code_onehot;

  johnson_code_check #(.N(N)) u_check (
    .jc_in (jc_in),
    .legal (code_legal),
    .idx   (code_idx)
  );

  // Successor of the held phase (wrapping at 2N-1) and whether the new code is that successor.
  always_comb begin
    if (phase_idx == LAST_IDX) begin
      next_idx = '0;
    end else begin
      next_idx = phase_idx + IW'(1);
    end
    step_ok     = code_legal && (code_idx == next_idx);
    cnt_inc     = cnt + 4'd1;
    code_onehot = {{(2*N-1){1'b0}}, 1'b1} << code_idx;
  end

  // Lock FSM with registered phase, locked and err; nothing moves while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= UNLOCKED;
      cnt          <= 4'd0;
      phase_idx    <= '0;
      phase_onehot <= {{(2*N-1){1'b0}}, 1'b1};
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!in_valid) begin
        state <= state;
      end else if (!code_legal) begin
        // Garbage code: phase holds, tracking is abandoned.
        state  <= UNLOCKED;
        cnt    <= 4'd0;
        locked <= 1'b0;
        err    <= 1'b1;
      end else begin
        phase_idx    <= code_idx;
        phase_onehot <= code_onehot;
        case (state)
          UNLOCKED: begin
            state  <= LOCKING;
            cnt    <= 4'd0;
            locked <= 1'b0;
          end
          LOCKING, LOCKED: begin
            if (!step_ok) begin
              // Legal code but skipped phase: re-seed from this code.
              state  <= LOCKING;
              cnt    <= 4'd0;
              locked <= 1'b0;
              err    <= 1'b1;
            end else if (state == LOCKED) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else if (cnt_inc == LOCK_TARGET) begin
              state  <= LOCKED;
              cnt    <= cnt_inc;
              locked <= 1'b1;
            end else begin
              state  <= LOCKING;
              cnt    <= cnt_inc;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= UNLOCKED;
            cnt    <= 4'd0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JPD_ERR_COUNT_EN
  // Count err pulses, sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 SHALL have parameter N, default 4, Johnson counter width (N >= 2).
REQ-002 SHALL have parameter LOCK_CNT, default 3, number of consecutive legal steps needed to declare lock (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port jc_in  input  N  Johnson code from the upstream counter's result output.
REQ-006 SHALL have port in_valid  input  1  jc_in sampled only when high.
REQ-007 SHALL have port phase_idx  output  $clog2(2N)  decoded phase index, registered.
REQ-008 SHALL have port phase_onehot  output  2N  one-hot phase, bit phase_idx set, registered.
REQ-009 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-010 SHALL have port err  output  1  one-cycle pulse on an illegal code or illegal step.

Function
REQ-011 SHALL define legal code of index i (0..2N-1) as: i<=N -> low i bits set; i>N -> inverse of (low i-N bits set), N bits wide (N=4: 0000,0001,0011,0111,1111,1110,1100,1000).
REQ-012 SHALL treat any other jc_in value as illegal.
REQ-013 SHALL define a legal step as a new index equal to (previous index + 1) mod 2N; wrap 2N-1 -> 0 is legal.
REQ-014 SHALL update phase_idx/phase_onehot one cycle after a valid legal code; on an illegal code they hold their previous value.
REQ-015 SHALL hold all state and outputs (err low) on cycles with in_valid low; a valid gap does not break the step sequence.
REQ-016 SHALL implement FSM states UNLOCKED, LOCKING, LOCKED, with a step counter cnt.
REQ-017 UNLOCKED: a valid legal code -> LOCKING, cnt=0; an illegal code stays in UNLOCKED and pulses err.
REQ-018 LOCKING: each legal step increments cnt; when cnt reaches LOCK_CNT -> LOCKED; an illegal code or step -> UNLOCKED with an err pulse.
REQ-019 LOCKING, illegal step with a legal code: the block SHALL re-seed phase from that code and go to LOCKING with cnt=0, instead of UNLOCKED.
REQ-020 LOCKED: a legal step stays in LOCKED; an illegal code -> UNLOCKED plus err; an illegal step with a legal code -> LOCKING with cnt=0 plus err.
REQ-021 SHALL assert locked in the same cycle the FSM register holds LOCKED (registered, no combinational path from jc_in).
REQ-022 SHALL raise err for exactly one cycle per offending valid sample.

Reset
REQ-023 On rst high, asynchronously: FSM=UNLOCKED, cnt=0, phase_idx=0, phase_onehot=1, locked=0, err=0.
REQ-024 Reset asserted mid-lock SHALL drop locked immediately; after release, locking SHALL restart from UNLOCKED.

Configuration
REQ-025 With JPD_ERR_COUNT_EN defined, the block SHALL add output err_cnt (8 bits, reset 0), incremented on each err pulse and saturating at 255.
REQ-026 Without JPD_ERR_COUNT_EN, err_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 A shared package jpd_pkg SHALL hold the FSM state enum (UNLOCKED, LOCKING, LOCKED) and the LOCK_CNT default constant.
REQ-028 Code-to-index decoding SHALL live in a combinational sub-module johnson_code_check (jc_in -> legal, idx), parameterised by N.

Verification (N=4, LOCK_CNT=3, driven by a 4-bit Johnson counter reset at t=0)
REQ-029 Reset release followed by codes 0000,0001,0011,0111: locked rises the cycle after 0111 is sampled; phase_idx=3; err never set.
REQ-030 Free-run through 1000 -> 0000: phase_idx wraps 7 -> 0, locked stays high, onehot=0000_0001.
REQ-031 While locked, inject 0101: err pulses for 1 cycle, locked falls, phase_idx holds its value.
REQ-032 While locked at idx 2, inject legal 1110 (idx 5): err pulses, FSM=LOCKING; three further legal steps bring locked back high.
REQ-033 Deassert in_valid for 5 cycles mid-sequence, then resume with the next code: no err, and lock is retained.
REQ-034 Assert rst while locked: locked and outputs go to reset values without a clock edge; with JPD_ERR_COUNT_EN, 300 forced errors leave err_cnt=255.
